t03_regfile_sb: RTL
===================

Name: t03_regfile_sb

Overview:
- Parametrised register file for the t03 core; successor of the single-write, two-read fixed 32x32 file.
- Configurable data width, depth and read-port count.
- Integrates the write-back source mux (ALU / memory / return address).
- Adds write-through read bypass and a load-pending scoreboard, so decode can stall on load-use hazards without external logic.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of two, >=2); AW = log2(NUM_REGS)
- NUM_RD, 2, combinational read ports (1..4)
- BYPASS, 1, 1 = a read of the register being written this cycle returns the new write data
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and writes to it are ignored

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  port i addresses a register with a pending load
- wr_en  in  1  write-back enable
- wr_addr  in  AW  write-back destination
- wr_sel  in  2  write source: 0 = wr_alu, 1 = wr_mem, 2 = wr_pc, 3 = reserved (no write)
- wr_alu  in  DATA_W  ALU result
- wr_mem  in  DATA_W  load data
- wr_pc  in  DATA_W  link value for jal/jalr
- ld_issue  in  1  a load leaves decode this cycle
- ld_addr  in  AW  destination of the issuing load
- flush  in  1  pipeline flush; clears all pending bits
- busy_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset (async, reset_n low):
  - all registers 0, all pending bits 0.
  - Consequently rd_data = 0, rd_busy = 0, busy_cnt = 0 while reset is held and immediately after release.
- Write:
  - On posedge clk with wr_en=1 and wr_sel!=3, reg[wr_addr] <= muxed source.
  - When ZERO_REG=1 and wr_addr=0, the write is dropped.
  - wr_sel=3 performs no write and does not touch scoreboard state.
- Read: combinational, zero latency.
  - With ZERO_REG=1, address 0 always reads 0.
  - With BYPASS=1, if wr_en, wr_sel!=3, rd_addr==wr_addr and the write is not dropped, rd_data returns the muxed write value in the same cycle; otherwise it returns the stored value.
- Scoreboard: one pending bit per register.
  - Set on posedge when ld_issue=1 for ld_addr; no set for register 0 when ZERO_REG=1.
  - Cleared on posedge by a write-back with wr_sel=1 to that address.
  - Same register set and cleared in the same cycle: set wins, because the newer load supersedes.
  - Clear with no pending bit: no effect. A second issue to an already-pending register stays pending.
  - flush=1 clears all bits at posedge; a ld_issue in the same cycle is ignored.
  - A flush does not cancel a register write in the same cycle.
- rd_busy[i] = pending[rd_addr_i], except it is 0 when BYPASS=1 and the same cycle carries the clearing wr_sel=1 write to that address, since the data is bypassed.
- busy_cnt: registered popcount, updated with the pending bits, so it matches the pending bits after each edge. Range 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1).
- Reset asserted mid-operation: asynchronously clears everything; in-flight writes are lost.

Decomposition:
- Shared package t03_pkg: enum wb_sel_t {WB_ALU=0, WB_MEM=1, WB_PC=2, WB_NONE=3}; default DATA_W and NUM_REGS constants.
- One natural sub-module, t03_regfile_scoreboard: pending bits, set/clear/flush priority, busy_cnt and rd_busy lookup.
- Storage, write mux and bypass stay in the top.

Test Plan:
- Reset: drive reset_n=0 mid-run after writing reg5=0xDEADBEEF -> rd_data for addr 5 reads 0 immediately; busy_cnt=0.
- Write/read: write wr_sel=0, wr_alu=0x12345678 to reg7, then read port0=7 and port1=0 next cycle -> 0x12345678 and 0. Same-cycle read of reg7 with BYPASS=1 -> 0x12345678; with BYPASS=0 -> old value.
- Zero register: write 0xFFFFFFFF with wr_sel=2 to reg0 -> reads 0. ld_issue to reg0 -> rd_busy=0, busy_cnt=0.
- Load-use: ld_issue to reg3 -> next cycle rd_busy[0]=1 for addr 3, busy_cnt=1. Then a wr_sel=1 write of 0xA5A5A5A5 to reg3 -> same cycle rd_busy=0 with data bypassed; next cycle busy_cnt=0.
- Simultaneous set/clear: ld_issue to reg4 in the same cycle as a wr_sel=1 write to reg4 -> reg4 stays pending and busy_cnt is unchanged.
- Flush: pend regs 1, 2 and 9, then flush with ld_issue to reg10 -> all rd_busy=0, busy_cnt=0, reg10 not pending.

Source files
------------

// File: rtl/t03_pkg.sv
// +--------------------------------------------------------------------+
// | t03_pkg : shared types and defaults for the t03 register file      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package t03_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

endpackage

`default_nettype wire

// File: rtl/t03_regfile_scoreboard.sv
// +--------------------------------------------------------------------+
// | t03_regfile_scoreboard : load-pending bits, busy lookup, busy count |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module t03_regfile_scoreboard
  import t03_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld_issue,
  input  logic [AW-1:0]        ld_addr,
  input  logic                 flush,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy,
  output logic [AW:0]          busy_cnt
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [AW:0]         busy_cnt_q;
  logic [AW:0]         busy_cnt_d;
  logic                w_set_ok;

  assign w_set_ok = ld_issue && !((ZERO_REG != 0) && (ld_addr == '0));

  // Set is applied after clear so a newer load to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (clr_en) pend_d[clr_addr] = 1'b0;
      if (w_set_ok) pend_d[ld_addr] = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + (AW+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [AW-1:0] w_addr;
    logic          w_bypassed;
    assign w_addr     = rd_addr[i*AW +: AW];
    // Load data arriving this cycle is forwarded, so the reader need not stall.
    assign w_bypassed = (BYPASS != 0) && clr_en && (clr_addr == w_addr);
    assign rd_busy[i] = pend_q[w_addr] && !w_bypassed;
  end

endmodule

`default_nettype wire

// File: rtl/t03_regfile_sb.sv
// +--------------------------------------------------------------------+
// | t03_regfile_sb : parametrised register file with write-back mux,   |
// | read bypass and load-use scoreboard                 rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module t03_regfile_sb
  import t03_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [1:0]               wr_sel,
  input  logic [DATA_W-1:0]        wr_alu,
  input  logic [DATA_W-1:0]        wr_mem,
  input  logic [DATA_W-1:0]        wr_pc,
  input  logic                     ld_issue,
  input  logic [AW-1:0]            ld_addr,
  input  logic                     flush,
  output logic [AW:0]              busy_cnt
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_live;
  logic              w_clr_en;

  always_comb begin
    w_wr_data = '0;
    case (wb_sel_t'(wr_sel))
      WB_ALU:  w_wr_data = wr_alu;
      WB_MEM:  w_wr_data = wr_mem;
      WB_PC:   w_wr_data = wr_pc;
      default: w_wr_data = '0;
    endcase
  end

  assign w_wr_live = wr_en && (wb_sel_t'(wr_sel) != WB_NONE) &&
                     !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_clr_en  = wr_en && (wb_sel_t'(wr_sel) == WB_MEM);

  always_comb begin
    regs_d = regs_q;
    if (w_wr_live) regs_d[wr_addr] = w_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_word;
    assign w_addr = rd_addr[i*AW +: AW];
    always_comb begin
      w_word = regs_q[w_addr];
      if ((BYPASS != 0) && w_wr_live && (wr_addr == w_addr)) w_word = w_wr_data;
      if ((ZERO_REG != 0) && (w_addr == '0)) w_word = '0;
    end
    assign rd_data[i*DATA_W +: DATA_W] = w_word;
  end

  t03_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .flush    (flush),
    .clr_en   (w_clr_en),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

endmodule

`default_nettype wire
